// File: rtl/instr_encoder_if.sv
// Instruction encoder bus: mnemonic-level fields with a valid/ready handshake
// on the way in, and the instruction memory write port on the way out.
// The master side is the producer (program loader or bench). The slave side
// is the encoder.
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);

   // Field handshake
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        op_sel;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       target;

   // Instruction memory write port
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_valid,
      output op_sel,
      output rs,
      output rt,
      output rd,
      output funct,
      output imm,
      output target,
      input  in_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );

   modport slave (
      input  in_valid,
      input  op_sel,
      input  rs,
      input  rt,
      input  rd,
      input  funct,
      input  imm,
      input  target,
      output in_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

endinterface

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: the inverse of the core's decode stage.
// It takes one set of mnemonic fields per handshake and packs them into a
// 32-bit word using the core's opcode map. It then writes the word into
// instruction memory at an address that auto-increments and wraps.
// Once DEPTH words have been written, the block parks in FULL until clear or reset.
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   instr_encoder_if.slave    bus,
   output logic [ADDR_W:0]   words_written,
   output logic              full,
   output logic              err,
   output logic              err_sticky
);

   // Mnemonic selector codes on op_sel
   localparam logic [3:0] SEL_R     = 4'd0;
   localparam logic [3:0] SEL_LW    = 4'd1;
   localparam logic [3:0] SEL_SW    = 4'd2;
   localparam logic [3:0] SEL_BEQ   = 4'd3;
   localparam logic [3:0] SEL_BNE   = 4'd4;
   localparam logic [3:0] SEL_ADDI  = 4'd5;
   localparam logic [3:0] SEL_ADDIU = 4'd6;
   localparam logic [3:0] SEL_ANDI  = 4'd7;
   localparam logic [3:0] SEL_ORI   = 4'd8;
   localparam logic [3:0] SEL_ANDIU = 4'd9;
   localparam logic [3:0] SEL_ORIU  = 4'd10;
   localparam logic [3:0] SEL_SLTIU = 4'd12;
   localparam logic [3:0] SEL_J     = 4'd13;

   // Core opcode map (bits [31:26] of the instruction word)
   localparam logic [5:0] OPC_R     = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_BNE   = 6'b000101;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_ADDIU = 6'b001001;
   localparam logic [5:0] OPC_ANDI  = 6'b100101;
   localparam logic [5:0] OPC_ORI   = 6'b100111;
   localparam logic [5:0] OPC_ANDIU = 6'b100100;
   localparam logic [5:0] OPC_ORIU  = 6'b100110;
   localparam logic [5:0] OPC_SLTIU = 6'b100010;
   localparam logic [5:0] OPC_J     = 6'b000001;

   localparam logic [ADDR_W-1:0] BASE      = BASE_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] ADDR_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_STEP  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   DEPTH_CNT = DEPTH[ADDR_W:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_ERR,
      S_FULL
   } state_t;

   state_t            state;
   logic              in_ready_q;
   logic              we_q;
   logic              err_q;
   logic              err_sticky_q;
   logic              full_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [ADDR_W:0]   count_q;

   logic [31:0]       enc_word;
   logic              enc_legal;
   logic              accept;
   logic [ADDR_W:0]   count_next;

   // Pack the current fields into an instruction word and flag selectors with
   // no usable opcode. SLTI (11) is rejected because its opcode collides with
   // LW, and decode always resolves that opcode as LW. 14 and 15 are unused.
   always_comb begin
      enc_word  = 32'h0000_0000;
      enc_legal = 1'b1;
      case (bus.op_sel)
         SEL_R:     enc_word = {OPC_R, bus.rs, bus.rt, bus.rd, 5'b00000, bus.funct};
         SEL_LW:    enc_word = {OPC_LW,    bus.rs, bus.rt, bus.imm};
         SEL_SW:    enc_word = {OPC_SW,    bus.rs, bus.rt, bus.imm};
         SEL_BEQ:   enc_word = {OPC_BEQ,   bus.rs, bus.rt, bus.imm};
         SEL_BNE:   enc_word = {OPC_BNE,   bus.rs, bus.rt, bus.imm};
         SEL_ADDI:  enc_word = {OPC_ADDI,  bus.rs, bus.rt, bus.imm};
         SEL_ADDIU: enc_word = {OPC_ADDIU, bus.rs, bus.rt, bus.imm};
         SEL_ANDI:  enc_word = {OPC_ANDI,  bus.rs, bus.rt, bus.imm};
         SEL_ORI:   enc_word = {OPC_ORI,   bus.rs, bus.rt, bus.imm};
         SEL_ANDIU: enc_word = {OPC_ANDIU, bus.rs, bus.rt, bus.imm};
         SEL_ORIU:  enc_word = {OPC_ORIU,  bus.rs, bus.rt, bus.imm};
         SEL_SLTIU: enc_word = {OPC_SLTIU, bus.rs, bus.rt, bus.imm};
         SEL_J:     enc_word = {OPC_J, bus.target};
         default:   enc_legal = 1'b0;
      endcase
   end

   // A handshake completes only in IDLE with ready high. A simultaneous clear
   // wins, so fields offered alongside clear are not taken.
   assign accept     = bus.in_valid && in_ready_q && (state == S_IDLE) && !clear;
   assign count_next = count_q + CNT_STEP;

   // Main control FSM. All outputs are registered here. Clear restarts the
   // image from BASE and takes priority over every state and over the handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         in_ready_q   <= 1'b1;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
         full_q       <= 1'b0;
         addr_q       <= BASE;
         wdata_q      <= 32'h0000_0000;
         count_q      <= '0;
      end else if (clear) begin
         state        <= S_IDLE;
         in_ready_q   <= 1'b1;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
         full_q       <= 1'b0;
         addr_q       <= BASE;
         count_q      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  in_ready_q <= 1'b0;
                  if (enc_legal) begin
                     wdata_q <= enc_word;
                     we_q    <= 1'b1;
                     state   <= S_WRITE;
                  end else begin
                     err_q        <= 1'b1;
                     err_sticky_q <= 1'b1;
                     state        <= S_ERR;
                  end
               end
            end
            S_WRITE: begin
               we_q    <= 1'b0;
               addr_q  <= addr_q + ADDR_STEP;
               count_q <= count_next;
               if (count_next == DEPTH_CNT) begin
                  full_q     <= 1'b1;
                  in_ready_q <= 1'b0;
                  state      <= S_FULL;
               end else begin
                  in_ready_q <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            S_ERR: begin
               err_q      <= 1'b0;
               in_ready_q <= 1'b1;
               state      <= S_IDLE;
            end
            S_FULL: begin
               in_ready_q <= 1'b0;
               full_q     <= 1'b1;
            end
            default: begin
               state      <= S_IDLE;
               in_ready_q <= 1'b1;
               we_q       <= 1'b0;
               err_q      <= 1'b0;
            end
         endcase
      end
   end

   // The write strobe and error pulse are masked by clear during their own
   // cycle. A restart therefore never lets memory or the error logic see an
   // action that the restart is about to discard.
   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = we_q && !clear;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign words_written  = count_q;
   assign full           = full_q;
   assign err            = err_q && !clear;
   assign err_sticky     = err_sticky_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder. Three instances share one stimulus stream:
// A uses the default parameters. B has DEPTH=4 and BASE_ADDR=0.
// C has DEPTH=4 and BASE_ADDR=254, so it exercises address wrap.
// Expected writes are pushed to a per-instance queue when a handshake is
// driven. A negedge monitor pops and compares those entries whenever a write
// strobe appears.
module tb_instr_encoder;

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
      logic        legal;
      logic [31:0] word;
   } vec_t;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] word;
   } exp_t;

   logic clk;
   logic reset;
   logic clear;

   logic [8:0] ww     [3];
   logic       full   [3];
   logic       err    [3];
   logic       sticky [3];

   instr_encoder_if #(.ADDR_W(8)) ifA ();
   instr_encoder_if #(.ADDR_W(8)) ifB ();
   instr_encoder_if #(.ADDR_W(8)) ifC ();

   // Instances B and C follow the producer signals of instance A
   assign ifB.in_valid = ifA.in_valid;
   assign ifB.op_sel   = ifA.op_sel;
   assign ifB.rs       = ifA.rs;
   assign ifB.rt       = ifA.rt;
   assign ifB.rd       = ifA.rd;
   assign ifB.funct    = ifA.funct;
   assign ifB.imm      = ifA.imm;
   assign ifB.target   = ifA.target;
   assign ifC.in_valid = ifA.in_valid;
   assign ifC.op_sel   = ifA.op_sel;
   assign ifC.rs       = ifA.rs;
   assign ifC.rt       = ifA.rt;
   assign ifC.rd       = ifA.rd;
   assign ifC.funct    = ifA.funct;
   assign ifC.imm      = ifA.imm;
   assign ifC.target   = ifA.target;

   instr_encoder #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dutA (
      .clk(clk), .reset(reset), .clear(clear), .bus(ifA.slave),
      .words_written(ww[0]), .full(full[0]), .err(err[0]), .err_sticky(sticky[0]));

   instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dutB (
      .clk(clk), .reset(reset), .clear(clear), .bus(ifB.slave),
      .words_written(ww[1]), .full(full[1]), .err(err[1]), .err_sticky(sticky[1]));

   instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(254)) dutC (
      .clk(clk), .reset(reset), .clear(clear), .bus(ifC.slave),
      .words_written(ww[2]), .full(full[2]), .err(err[2]), .err_sticky(sticky[2]));

   int checkCount = 0;
   int errorCount = 0;

   exp_t qA[$];
   exp_t qB[$];
   exp_t qC[$];

   logic [7:0] mAddr  [3];
   logic [7:0] mBase  [3];
   int         mCount [3];
   int         mDepth [3];
   int         mErr   [3];
   int         errSeen[3];

   vec_t vecs[18];

   // Free-running clock with a 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something never returns
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkWrite(input int d, input logic [7:0] addr, input logic [31:0] data);
      exp_t e;
      int   sz;
      sz = (d == 0) ? qA.size() : (d == 1) ? qB.size() : qC.size();
      if (sz == 0) begin
         checkCount++;
         errorCount++;
         $display("[TB] FAIL unexpected_write dut%0d: got addr 0x%0h data 0x%0h expected no write", d, addr, data);
      end else begin
         if (d == 0)      e = qA.pop_front();
         else if (d == 1) e = qB.pop_front();
         else             e = qC.pop_front();
         checkOutput($sformatf("write_addr_dut%0d", d), {24'h0, addr}, {24'h0, e.addr});
         checkOutput($sformatf("write_data_dut%0d", d), data, e.word);
      end
   endtask

   // Monitor: score write strobes and count error pulses on the falling edge
   always @(negedge clk) begin
      if (ifA.imem_we === 1'b1) checkWrite(0, ifA.imem_addr, ifA.imem_wdata);
      if (ifB.imem_we === 1'b1) checkWrite(1, ifB.imem_addr, ifB.imem_wdata);
      if (ifC.imem_we === 1'b1) checkWrite(2, ifC.imem_addr, ifC.imem_wdata);
      for (int d = 0; d < 3; d++) if (err[d] === 1'b1) errSeen[d]++;
   end

   task automatic resetModels();
      for (int d = 0; d < 3; d++) begin
         mAddr[d]  = mBase[d];
         mCount[d] = 0;
      end
   endtask

   task automatic setFields(input vec_t v);
      ifA.op_sel = v.op;
      ifA.rs     = v.rs;
      ifA.rt     = v.rt;
      ifA.rd     = v.rd;
      ifA.funct  = v.funct;
      ifA.imm    = v.imm;
      ifA.target = v.target;
   endtask

   // Offer one vector and update each instance model. Then check the first
   // cycle after acceptance on A.
   task automatic applyStimulus(input vec_t v);
      int waitCycles = 0;
      while (ifA.in_ready !== 1'b1 && waitCycles < 20) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      if (ifA.in_ready !== 1'b1) begin
         checkOutput("ready_timeout", {31'h0, ifA.in_ready}, 32'h1);
      end else begin
         setFields(v);
         ifA.in_valid = 1'b1;
         for (int d = 0; d < 3; d++) begin
            if (mCount[d] != mDepth[d]) begin
               if (v.legal) begin
                  if (d == 0)      qA.push_back('{mAddr[d], v.word});
                  else if (d == 1) qB.push_back('{mAddr[d], v.word});
                  else             qC.push_back('{mAddr[d], v.word});
                  mAddr[d] = mAddr[d] + 8'd1;
                  mCount[d]++;
               end else begin
                  mErr[d]++;
               end
            end
         end
         @(posedge clk);
         #1;
         ifA.in_valid = 1'b0;
         checkOutput("ready_low_after_accept", {31'h0, ifA.in_ready}, 32'h0);
         checkOutput("we_latency", {31'h0, ifA.imem_we}, {31'h0, v.legal});
         checkOutput("err_latency", {31'h0, err[0]}, {31'h0, !v.legal});
      end
   endtask

   // Handshake that is expected to be aborted or refused. The scoreboard
   // receives nothing for it.
   task automatic pulseUnscored(input vec_t v);
      setFields(v);
      ifA.in_valid = 1'b1;
      @(posedge clk);
      #1;
      ifA.in_valid = 1'b0;
   endtask

   task automatic doClear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      resetModels();
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{4'd5,  5'd1,  5'd2,  5'd31, 6'd63,  16'h0005, 26'h3FFFFFF, 1'b1, 32'h20220005};
      vecs[1]  = '{4'd0,  5'd1,  5'd2,  5'd3,  6'h20,  16'hFFFF, 26'h0,       1'b1, 32'h00221820};
      vecs[2]  = '{4'd1,  5'd29, 5'd8,  5'd0,  6'h0,   16'h0004, 26'h0,       1'b1, 32'h8FA80004};
      vecs[3]  = '{4'd13, 5'd5,  5'd6,  5'd7,  6'h1,   16'h1234, 26'h10,      1'b1, 32'h04000010};
      vecs[4]  = '{4'd3,  5'd1,  5'd2,  5'd0,  6'h0,   16'hFFFF, 26'h0,       1'b1, 32'h1022FFFF};
      vecs[5]  = '{4'd11, 5'd1,  5'd2,  5'd0,  6'h0,   16'h0005, 26'h0,       1'b0, 32'h0};
      vecs[6]  = '{4'd15, 5'd3,  5'd4,  5'd5,  6'h6,   16'h0007, 26'h8,       1'b0, 32'h0};
      vecs[7]  = '{4'd2,  5'd2,  5'd3,  5'd0,  6'h0,   16'h0010, 26'h0,       1'b1, 32'hAC430010};
      vecs[8]  = '{4'd4,  5'd4,  5'd5,  5'd0,  6'h0,   16'h8000, 26'h0,       1'b1, 32'h14858000};
      vecs[9]  = '{4'd6,  5'd0,  5'd31, 5'd0,  6'h0,   16'h1234, 26'h0,       1'b1, 32'h241F1234};
      vecs[10] = '{4'd7,  5'd7,  5'd6,  5'd0,  6'h0,   16'h00FF, 26'h0,       1'b1, 32'h94E600FF};
      vecs[11] = '{4'd14, 5'd1,  5'd1,  5'd1,  6'h1,   16'h0001, 26'h1,       1'b0, 32'h0};
      vecs[12] = '{4'd8,  5'd31, 5'd0,  5'd0,  6'h0,   16'hABCD, 26'h0,       1'b1, 32'h9FE0ABCD};
      vecs[13] = '{4'd9,  5'd1,  5'd1,  5'd0,  6'h0,   16'h0001, 26'h0,       1'b1, 32'h90210001};
      vecs[14] = '{4'd10, 5'd2,  5'd2,  5'd0,  6'h0,   16'h0002, 26'h0,       1'b1, 32'h98420002};
      vecs[15] = '{4'd12, 5'd3,  5'd4,  5'd0,  6'h0,   16'h7FFF, 26'h0,       1'b1, 32'h88647FFF};
      vecs[16] = '{4'd0,  5'd31, 5'd31, 5'd31, 6'h3F,  16'h0000, 26'h0,       1'b1, 32'h03FFF83F};
      vecs[17] = '{4'd13, 5'd0,  5'd0,  5'd0,  6'h0,   16'h0000, 26'h3FFFFFF, 1'b1, 32'h07FFFFFF};

      mBase  = '{8'd0, 8'd0, 8'd254};
      mDepth = '{256, 4, 4};
      mErr   = '{0, 0, 0};
      errSeen = '{0, 0, 0};
      resetModels();

      reset = 1'b1;
      clear = 1'b0;
      ifA.in_valid = 1'b0;
      setFields(vecs[0]);

      // Reset values while reset is held
      #12;
      checkOutput("rst_in_ready", {31'h0, ifA.in_ready}, 32'h1);
      checkOutput("rst_we", {31'h0, ifA.imem_we}, 32'h0);
      checkOutput("rst_addr", {24'h0, ifA.imem_addr}, 32'h0);
      checkOutput("rst_wdata", ifA.imem_wdata, 32'h0);
      checkOutput("rst_ww", {23'h0, ww[0]}, 32'h0);
      checkOutput("rst_full", {31'h0, full[0]}, 32'h0);
      checkOutput("rst_err", {31'h0, err[0]}, 32'h0);
      checkOutput("rst_sticky", {31'h0, sticky[0]}, 32'h0);
      checkOutput("rst_addr_base254", {24'h0, ifC.imem_addr}, 32'd254);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Table pass with checkpoints at the multi-cycle corner cases
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i]);
         if (i == 0) begin
            settle();
            checkOutput("ww_after_first", {23'h0, ww[0]}, 32'd1);
         end
         if (i == 4) begin
            settle();
            checkOutput("ww_a_five", {23'h0, ww[0]}, 32'd5);
            checkOutput("full_b", {31'h0, full[1]}, 32'h1);
            checkOutput("ready_b_full", {31'h0, ifB.in_ready}, 32'h0);
            checkOutput("ww_b_capped", {23'h0, ww[1]}, 32'd4);
            checkOutput("full_c", {31'h0, full[2]}, 32'h1);
         end
         if (i == 6) begin
            settle();
            checkOutput("err_pulses", errSeen[0], 32'd2);
            checkOutput("sticky_a", {31'h0, sticky[0]}, 32'h1);
            checkOutput("addr_unchanged_by_err", {24'h0, ifA.imem_addr}, 32'd5);
            checkOutput("ww_unchanged_by_err", {23'h0, ww[0]}, 32'd5);
            checkOutput("sticky_b_full_ignores", {31'h0, sticky[1]}, 32'h0);
         end
      end
      settle();
      checkOutput("ww_a_total", {23'h0, ww[0]}, mCount[0]);
      checkOutput("err_total_a", errSeen[0], mErr[0]);
      checkOutput("err_total_b", errSeen[1], mErr[1]);

      // Clear returns every instance to a fresh image
      doClear();
      checkOutput("clr_addr_a", {24'h0, ifA.imem_addr}, 32'h0);
      checkOutput("clr_ww_a", {23'h0, ww[0]}, 32'h0);
      checkOutput("clr_sticky_a", {31'h0, sticky[0]}, 32'h0);
      checkOutput("clr_ready_a", {31'h0, ifA.in_ready}, 32'h1);
      checkOutput("clr_full_b", {31'h0, full[1]}, 32'h0);
      checkOutput("clr_ready_b", {31'h0, ifB.in_ready}, 32'h1);
      checkOutput("clr_ww_b", {23'h0, ww[1]}, 32'h0);
      checkOutput("clr_addr_c", {24'h0, ifC.imem_addr}, 32'd254);

      // Four writes fill B and C, and C wraps from 255 to 0
      for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);
      settle();
      checkOutput("fill_full_b", {31'h0, full[1]}, 32'h1);
      checkOutput("fill_addr_b", {24'h0, ifB.imem_addr}, 32'd4);
      checkOutput("fill_full_c", {31'h0, full[2]}, 32'h1);
      checkOutput("fill_addr_c_wrapped", {24'h0, ifC.imem_addr}, 32'd2);
      applyStimulus(vecs[4]);
      settle();
      checkOutput("full_ignores_ww_c", {23'h0, ww[2]}, 32'd4);
      checkOutput("full_ignores_ready_c", {31'h0, ifC.in_ready}, 32'h0);
      doClear();

      // Clear during WRITE aborts the strobe in that cycle
      pulseUnscored(vecs[7]);
      checkOutput("we_before_clear", {31'h0, ifA.imem_we}, 32'h1);
      clear = 1'b1;
      #1;
      checkOutput("we_aborted_by_clear", {31'h0, ifA.imem_we}, 32'h0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      resetModels();
      checkOutput("abort_addr_a", {24'h0, ifA.imem_addr}, 32'h0);
      checkOutput("abort_ww_a", {23'h0, ww[0]}, 32'h0);
      checkOutput("abort_ready_a", {31'h0, ifA.in_ready}, 32'h1);
      checkOutput("abort_addr_c", {24'h0, ifC.imem_addr}, 32'd254);

      // Fields offered together with clear are refused
      clear = 1'b1;
      pulseUnscored(vecs[0]);
      clear = 1'b0;
      checkOutput("clear_refuses_ready", {31'h0, ifA.in_ready}, 32'h1);
      checkOutput("clear_refuses_we", {31'h0, ifA.imem_we}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("clear_refuses_ww", {23'h0, ww[0]}, 32'h0);

      // Reset in the middle of a write drops the strobe asynchronously
      pulseUnscored(vecs[9]);
      checkOutput("we_before_reset", {31'h0, ifA.imem_we}, 32'h1);
      reset = 1'b1;
      #1;
      checkOutput("reset_drops_we", {31'h0, ifA.imem_we}, 32'h0);
      checkOutput("reset_ready", {31'h0, ifA.in_ready}, 32'h1);
      checkOutput("reset_addr_a", {24'h0, ifA.imem_addr}, 32'h0);
      checkOutput("reset_wdata_a", ifA.imem_wdata, 32'h0);
      checkOutput("reset_addr_c", {24'h0, ifC.imem_addr}, 32'd254);
      @(negedge clk);
      reset = 1'b0;
      resetModels();
      settle();

      // One more write after reset lands at the base address
      applyStimulus(vecs[16]);
      settle();
      checkOutput("post_reset_ww", {23'h0, ww[0]}, 32'd1);
      checkOutput("scoreboard_drained", qA.size() + qB.size() + qC.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
